// File: rtl/fifo_lifo_pkg.sv
// Shared FIFO/LIFO definitions: default geometry and the per-cycle stack operation code.
package fifo_lifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stack_op_t;
endpackage

// File: rtl/lifo_ram.sv
// Storage array for the stack: synchronous write, asynchronous read, contents not reset.
module lifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lifo_stack.sv
// LIFO buffer: sp is the entry count, top lives at mem[sp-1]; popped data is registered
// with a one-cycle valid, and rejected pushes/pops raise one-cycle error pulses.
module lifo_stack
  import fifo_lifo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH + 1),
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             dout_valid,
  output logic [PTR_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] data_out_q;
  logic             dout_valid_q, overflow_q, underflow_q;
  stack_op_t        op;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr, ram_raddr;
  logic [WIDTH-1:0] ram_rdata;
  logic [PTR_W-1:0] sp_m1;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == PTR_W'(DEPTH));
  assign sp_m1 = sp_q - PTR_W'(1);

  always_comb begin
    op = OP_IDLE;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_IDLE;
    endcase
  end

  // Replace overwrites the current top in place; a plain push fills the next free slot.
  // The empty-replace bypass never touches the RAM.
  assign ram_we    = ((op == OP_PUSH) && !full) || ((op == OP_REPLACE) && !empty);
  assign ram_waddr = (op == OP_REPLACE) ? AW'(sp_m1) : AW'(sp_q);
  assign ram_raddr = AW'(sp_m1);

  lifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (data_in),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    sp_d = sp_q;
    if (op == OP_PUSH && !full)  sp_d = sp_q + PTR_W'(1);
    if (op == OP_POP  && !empty) sp_d = sp_m1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q         <= '0;
      data_out_q   <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      sp_q         <= sp_d;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      case (op)
        OP_PUSH: if (full) overflow_q <= 1'b1;
        OP_POP: begin
          if (empty) underflow_q <= 1'b1;
          else begin
            data_out_q   <= ram_rdata;
            dout_valid_q <= 1'b1;
          end
        end
        OP_REPLACE: begin
          data_out_q   <= empty ? data_in : ram_rdata;
          dout_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign dout_valid = dout_valid_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign count      = sp_q;
endmodule

// File: tb/tb_lifo_stack.sv
// Scoreboard bench for lifo_stack: a queue-based stack model predicts flags and pop data.
module tb_lifo_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0, pop = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             dout_valid, empty, full, overflow, underflow;
  logic [PTR_W-1:0] count;

  int n_chk = 0;
  int n_pass = 0;

  logic [WIDTH-1:0] mdl[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] last_dout = '0;

  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .data_in    (data_in),
    .data_out   (data_out),
    .dout_valid (dout_valid),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(mdl.size()));
    chk({tag, "_empty"}, 32'(empty), 32'(mdl.size() == 0));
    chk({tag, "_full"},  32'(full),  32'(mdl.size() == DEPTH));
  endtask

  // One clocked operation: predict, drive, clock, compare.
  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
    logic e_v, e_o, e_u;
    logic [WIDTH-1:0] e;
    e_v = 1'b0; e_o = 1'b0; e_u = 1'b0;
    if (p && !q) begin
      if (mdl.size() < DEPTH) mdl.push_back(d);
      else e_o = 1'b1;
    end else if (!p && q) begin
      if (mdl.size() > 0) begin exp_q.push_back(mdl.pop_back()); e_v = 1'b1; end
      else e_u = 1'b1;
    end else if (p && q) begin
      e_v = 1'b1;
      if (mdl.size() > 0) begin
        exp_q.push_back(mdl[mdl.size()-1]);
        mdl[mdl.size()-1] = d;
      end else exp_q.push_back(d);
    end
    push = p; pop = q; data_in = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    chk("dout_valid", 32'(dout_valid), 32'(e_v));
    chk("overflow",   32'(overflow),   32'(e_o));
    chk("underflow",  32'(underflow),  32'(e_u));
    chk_idle_state("op");
    if (dout_valid) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", 32'(1), 32'(0));
      else begin
        e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(e));
        last_dout = e;
      end
    end else chk("data_out_hold", 32'(data_out), 32'(last_dout));
  endtask

  task automatic model_reset();
    mdl.delete();
    exp_q.delete();
    last_dout = '0;
  endtask

  initial begin
    // 1: reset held with push toggling
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push = i[0]; data_in = 8'hE0 + 8'(i);
      @(posedge clk); #1;
    end
    push = 1'b0;
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full",  32'(full),  32'(0));
    chk("rst_dout",  32'(data_out), 32'(0));
    chk("rst_pulses", 32'({dout_valid, overflow, underflow}), 32'(0));
    reset = 1'b1;
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    // 2: LIFO order
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    // 3: fill, overflow, pop
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i));
    step(1, 0, 8'hAA);
    step(0, 1, 8'h00);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 8'h00);
    // 4: underflow from empty
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    // 5: simultaneous push/pop
    step(1, 0, 8'h01);
    step(1, 0, 8'h02);
    step(1, 1, 8'h55);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(1, 1, 8'h66);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'h40 + 8'(i));
    step(1, 1, 8'h77);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
    // 6: reset pulsed between edges after 5 pushes
    for (int i = 0; i < 5; i++) step(1, 0, 8'h90 + 8'(i));
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_empty", 32'(empty), 32'(1));
    chk("midrst_dout",  32'(data_out), 32'(0));
    #2 reset = 1'b1;
    step(0, 1, 8'h00);
    // random mix
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    chk("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
